// File: rtl/mii_frame_capture_pkg.sv
`default_nettype none
// ============================================================================
// eth_pkg : shared types, constants and nibble-packing helper for MII capture
// Revision: 1.0
// ============================================================================
package eth_pkg;

  localparam int FRAME_ADDR_W = 9;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    CAPTURE     = 3'd1,
    FLUSH       = 3'd2,
    CHECK       = 3'd3,
    WAIT_PARSER = 3'd4,
    DISCARD     = 3'd5
  } state_t;

  // Nibble idx lands in byte idx/2; the first nibble of a byte takes the upper half.
  function automatic logic [31:0] pack_nibble(input logic [31:0] word,
                                               input logic [2:0]  idx,
                                               input logic [3:0]  nib);
    logic [31:0] packed_w;
    packed_w = word;
    packed_w[{idx[2:1], ~idx[0], 2'b00} +: 4] = nib;
    return packed_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mii_frame_capture_if.sv
`default_nettype none
// ============================================================================
// mii_frame_capture_if : MII receive, frame RAM write and parser handshake
// Revision: 1.0
// ============================================================================
interface mii_frame_capture_if #(
  parameter int ADDR_W = 9
);
  logic              rx_dv;
  logic              rx_er;
  logic [3:0]        rxd;
  logic              parser_done;
  logic              wr_ena;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              newpacket;
  logic [ADDR_W-1:0] last_addr;
  logic              busy;
  logic [15:0]       drop_count;

  modport master (
    input  rx_dv, rx_er, rxd, parser_done,
    output wr_ena, wr_addr, wr_data, newpacket, last_addr, busy, drop_count
  );

  modport slave (
    output rx_dv, rx_er, rxd, parser_done,
    input  wr_ena, wr_addr, wr_data, newpacket, last_addr, busy, drop_count
  );
endinterface
`default_nettype wire

// File: rtl/mii_frame_capture_packer.sv
`default_nettype none
// ============================================================================
// mii_nibble_packer : packs 8 MII nibbles into a 32-bit word, pulses word_valid
// Revision: 1.0
// ============================================================================
module mii_nibble_packer
  import eth_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear_i,
  input  logic        nib_valid_i,
  input  logic [3:0]  nib_i,
  output logic [31:0] word_o,
  output logic        word_valid_o,
  output logic [2:0]  count_o
);

  logic [2:0]  cnt_q,   cnt_d;
  logic [31:0] word_q,  word_d;
  logic        valid_q, valid_d;

  always_comb begin
    cnt_d   = cnt_q;
    word_d  = word_q;
    valid_d = 1'b0;
    if (clear_i) begin
      cnt_d = 3'd0;
    end else if (nib_valid_i) begin
      // Nibble 0 starts from zero so a partial word has its unfilled nibbles cleared.
      word_d  = pack_nibble((cnt_q == 3'd0) ? 32'd0 : word_q, cnt_q, nib_i);
      cnt_d   = cnt_q + 3'd1;
      valid_d = (cnt_q == 3'd7);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= 3'd0;
      word_q  <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end

  assign word_o       = word_q;
  assign word_valid_o = valid_q;
  assign count_o      = cnt_q;

endmodule
`default_nettype wire

// File: rtl/mii_frame_capture.sv
`default_nettype none
// ============================================================================
// mii_frame_capture : captures MII frames into frame RAM and hands them to parser
// Revision: 1.0
// ============================================================================
module mii_frame_capture
  import eth_pkg::*;
#(
  parameter int ADDR_W    = FRAME_ADDR_W,
  parameter int MAX_WORDS = 512,
  parameter int MIN_WORDS = 16
) (
  input logic                 clk,
  input logic                 rst,
  mii_frame_capture_if.master bus
);

  localparam int CNT_W = $clog2(MAX_WORDS + 1);

  state_t            state_q, state_d;
  logic              rx_dv_q;
  logic              armed_q;
  logic [CNT_W-1:0]  words_q, words_d;
  logic [ADDR_W-1:0] last_addr_q, last_addr_d;
  logic [15:0]       drop_q, drop_d;

  logic              w_rise, w_store, w_clear, w_full, w_drop, w_notify, w_wr_ena;
  logic [31:0]       w_word;
  logic              w_word_valid;
  logic [2:0]        w_count;

  // armed_q blocks a capture until rx_dv has been seen low after reset.
  assign w_rise   = bus.rx_dv & ~rx_dv_q & armed_q;
  assign w_wr_ena = w_word_valid | (state_q == FLUSH);
  assign w_full   = (words_q + CNT_W'(w_word_valid)) >= CNT_W'(MAX_WORDS);
  assign w_clear  = (state_q != IDLE) && (state_q != CAPTURE);

  mii_nibble_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (w_clear),
    .nib_valid_i  (w_store),
    .nib_i        (bus.rxd),
    .word_o       (w_word),
    .word_valid_o (w_word_valid),
    .count_o      (w_count)
  );

  always_comb begin
    state_d     = state_q;
    words_d     = w_wr_ena ? words_q + CNT_W'(1) : words_q;
    last_addr_d = last_addr_q;
    w_store     = 1'b0;
    w_drop      = 1'b0;
    w_notify    = 1'b0;
    case (state_q)
      IDLE: begin
        if (w_rise) begin
          state_d = CAPTURE;
          words_d = '0;
          w_store = 1'b1;
        end
      end
      CAPTURE: begin
        if (bus.rx_dv) begin
          if (bus.rx_er || w_full) begin
            state_d = DISCARD;
            w_drop  = 1'b1;
          end else begin
            w_store = 1'b1;
          end
        end else if (w_count != 3'd0) begin
          state_d = FLUSH;
        end else begin
          state_d = CHECK;
        end
      end
      FLUSH: state_d = CHECK;
      CHECK: begin
        if (words_q < CNT_W'(MIN_WORDS)) begin
          state_d = IDLE;
          w_drop  = 1'b1;
        end else begin
          state_d     = WAIT_PARSER;
          w_notify    = 1'b1;
          last_addr_d = ADDR_W'(words_q - CNT_W'(1));
        end
      end
      WAIT_PARSER: begin
        w_drop = w_rise;
        if (bus.parser_done) state_d = IDLE;
      end
      DISCARD: begin
        if (!bus.rx_dv) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    drop_d = (w_drop && (drop_q != 16'hFFFF)) ? drop_q + 16'd1 : drop_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rx_dv_q     <= 1'b0;
      armed_q     <= 1'b0;
      words_q     <= '0;
      last_addr_q <= '0;
      drop_q      <= 16'd0;
    end else begin
      state_q     <= state_d;
      rx_dv_q     <= bus.rx_dv;
      armed_q     <= armed_q | ~bus.rx_dv;
      words_q     <= words_d;
      last_addr_q <= last_addr_d;
      drop_q      <= drop_d;
    end
  end

  assign bus.wr_ena     = w_wr_ena;
  assign bus.wr_addr    = ADDR_W'(words_q);
  assign bus.wr_data    = w_word;
  assign bus.newpacket  = w_notify;
  assign bus.last_addr  = w_notify ? last_addr_d : last_addr_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.drop_count = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_mii_frame_capture.sv
`default_nettype none
// ============================================================================
// tb_mii_frame_capture : directed self-checking bench for mii_frame_capture
// Revision: 1.0
// ============================================================================
module tb_mii_frame_capture;
  import eth_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mii_frame_capture_if #(.ADDR_W(9)) bus ();

  mii_frame_capture #(
    .ADDR_W    (9),
    .MAX_WORDS (512),
    .MIN_WORDS (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] mem  [512];
  logic [8:0]  wlog [4096];
  int          wr_cnt = 0;
  int          np_cnt = 0;
  logic [8:0]  np_last = '0;

  // Frame RAM model and write/notify log, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.wr_ena === 1'b1) begin
      mem[bus.wr_addr] = bus.wr_data;
      if (wr_cnt < 4096) wlog[wr_cnt] = bus.wr_addr;
      wr_cnt++;
    end
    if (bus.newpacket === 1'b1) begin
      np_cnt++;
      np_last = bus.last_addr;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_nib(input logic [3:0] n);
    bus.rx_dv = 1'b1;
    bus.rx_er = 1'b0;
    bus.rxd   = n;
    tick();
  endtask

  // Low nibble on the wire first; it packs into the upper half of its byte.
  task automatic send_byte(input logic [7:0] b);
    send_nib(b[3:0]);
    send_nib(b[7:4]);
  endtask

  task automatic end_frame(input int n);
    bus.rx_dv = 1'b0;
    bus.rxd   = 4'h0;
    repeat (n) tick();
  endtask

  // Preamble + SFD + 64 data bytes base..base+63: 18 words.
  task automatic send_frame(input logic [7:0] base);
    repeat (7) send_byte(PREAMBLE_BYTE);
    send_byte(SFD_BYTE);
    for (int i = 0; i < 64; i++) send_byte(base + 8'(i));
  endtask

  task automatic pulse_done();
    bus.parser_done = 1'b1;
    tick();
    bus.parser_done = 1'b0;
    tick();
  endtask

  int wb, nb, werr, bad;

  initial begin
    bus.rx_dv = 1'b0; bus.rx_er = 1'b0; bus.rxd = 4'h0; bus.parser_done = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    check("rst_busy",      bus.busy,       0);
    check("rst_drop",      bus.drop_count, 0);
    check("rst_wr_ena",    bus.wr_ena,     0);
    check("rst_newpacket", bus.newpacket,  0);
    check("rst_last_addr", bus.last_addr,  0);
    check("rst_wr_addr",   bus.wr_addr,    0);
    check("rst_wr_data",   bus.wr_data,    0);
    rst = 1'b0;
    tick();

    // Normal 72-byte frame.
    wb = wr_cnt; nb = np_cnt;
    send_frame(8'h00);
    end_frame(5);
    check("t1_writes", wr_cnt - wb, 18);
    check("t1_w0",     mem[0],  32'h55555555);
    check("t1_w1",     mem[1],  32'h5D555555);
    check("t1_w2",     mem[2],  32'h30201000);
    check("t1_w17",    mem[17], 32'hF3E3D3C3);
    bad = 0;
    for (int i = 0; i < 18; i++) if (wlog[wb + i] !== 9'(i)) bad++;
    check("t1_addr_seq", bad, 0);
    check("t1_np",       np_cnt - nb, 1);
    check("t1_np_last",  np_last, 17);
    check("t1_last",     bus.last_addr, 17);
    check("t1_busy",     bus.busy, 1);
    repeat (10) tick();
    check("t1_busy_hold", bus.busy, 1);
    check("t1_np_once",   np_cnt - nb, 1);
    pulse_done();
    check("t1_released",  bus.busy, 0);

    // 32 bytes + one nibble: flushed partial word, then too short.
    wb = wr_cnt; nb = np_cnt;
    for (int i = 0; i < 32; i++) send_byte(8'(i));
    send_nib(4'hA);
    end_frame(6);
    check("t2_writes", wr_cnt - wb, 9);
    check("t2_flush",  mem[8], 32'h000000A0);
    check("t2_np",     np_cnt - nb, 0);
    check("t2_drop",   bus.drop_count, 1);
    check("t2_busy",   bus.busy, 0);

    // rx_er on nibble index 40 of a 100-byte frame.
    wb = wr_cnt; nb = np_cnt; werr = 0;
    for (int k = 0; k < 200; k++) begin
      bus.rx_dv = 1'b1;
      bus.rx_er = (k == 40);
      bus.rxd   = 4'h5;
      tick();
      if (k == 40) werr = wr_cnt;
    end
    bus.rx_er = 1'b0;
    check("t3_discard_busy", bus.busy, 1);
    end_frame(5);
    check("t3_writes_before", werr - wb, 5);
    check("t3_writes_after",  wr_cnt - werr, 0);
    check("t3_np",            np_cnt - nb, 0);
    check("t3_drop",          bus.drop_count, 2);
    check("t3_busy",          bus.busy, 0);

    // 2100-byte frame overflows the RAM.
    wb = wr_cnt; nb = np_cnt;
    for (int k = 0; k < 2100; k++) send_byte(8'(k));
    end_frame(5);
    check("t4_writes", wr_cnt - wb, 512);
    bad = 0;
    for (int i = 0; i < 512; i++) if (wlog[wb + i] !== 9'(i)) bad++;
    check("t4_addr_seq", bad, 0);
    check("t4_w0",       mem[0],   32'h30201000);
    check("t4_w511",     mem[511], 32'hFFEFDFCF);
    check("t4_np",       np_cnt - nb, 0);
    check("t4_drop",     bus.drop_count, 3);
    check("t4_busy",     bus.busy, 0);

    // Frame arriving while RAM is held; release lands mid-frame.
    nb = np_cnt;
    send_frame(8'h40);
    end_frame(5);
    check("t5_np_first", np_cnt - nb, 1);
    wb = wr_cnt; nb = np_cnt;
    for (int k = 0; k < 80; k++) begin
      bus.rx_dv       = 1'b1;
      bus.rxd         = 4'(k);
      bus.parser_done = (k == 20);
      tick();
      bus.parser_done = 1'b0;
    end
    check("t5_idle_midframe", bus.busy, 0);
    end_frame(3);
    check("t5_drop",    bus.drop_count, 4);
    check("t5_writes2", wr_cnt - wb, 0);
    check("t5_np2",     np_cnt - nb, 0);
    wb = wr_cnt; nb = np_cnt;
    send_frame(8'h80);
    end_frame(5);
    check("t5_writes3",  wr_cnt - wb, 18);
    check("t5_first_addr", wlog[wb], 0);
    check("t5_w2",       mem[2], 32'h38281808);
    check("t5_np3",      np_cnt - nb, 1);
    check("t5_np_last",  np_last, 17);
    pulse_done();

    // Reset mid-frame with rx_dv held high.
    for (int k = 0; k < 20; k++) send_nib(4'h5);
    rst = 1'b1;
    tick();
    tick();
    check("t6_busy",      bus.busy, 0);
    check("t6_drop",      bus.drop_count, 0);
    check("t6_wr_ena",    bus.wr_ena, 0);
    check("t6_newpacket", bus.newpacket, 0);
    check("t6_last",      bus.last_addr, 0);
    check("t6_wr_addr",   bus.wr_addr, 0);
    rst = 1'b0;
    wb = wr_cnt;
    for (int k = 0; k < 40; k++) send_nib(4'h5);
    check("t6_no_capture", bus.busy, 0);
    check("t6_no_writes",  wr_cnt - wb, 0);
    end_frame(3);
    wb = wr_cnt; nb = np_cnt;
    send_frame(8'h00);
    end_frame(5);
    check("t6_writes", wr_cnt - wb, 18);
    check("t6_np",     np_cnt - nb, 1);
    check("t6_w2",     mem[2], 32'h30201000);
    pulse_done();
    check("t6_released", bus.busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
